// File: rtl/jtframe_colmix_nl_if.sv
// CPU-side palette bus of the colour mixer: chip select, word address,
// write data, active-low byte strobes and registered read data.
interface jtframe_colmix_nl_if #(
  parameter int PAL_AW = 10
);
  logic              pal_cs;
  logic [PAL_AW-1:0] cpu_addr;
  logic [15:0]       cpu_dout;
  logic [1:0]        dsn;
  logic [15:0]       cpu_din;

  modport master (output pal_cs, cpu_addr, cpu_dout, dsn, input cpu_din);
  modport slave  (input pal_cs, cpu_addr, cpu_dout, dsn, output cpu_din);
endinterface

// File: rtl/jtframe_colmix_nl.sv
// N-layer colour mixer: layer select (fixed order or priority PROM), 12-bit
// BGR palette lookup, 8-bit expansion and frame-stepped brightness fade.
module jtframe_colmix_nl #(
  parameter int LAYERS    = 4,
  parameter int PXLW      = 8,
  parameter int PRIO_MODE = 1,
  parameter int SELW      = $clog2(LAYERS),
  parameter int PRIO_AW   = LAYERS + 3,
  parameter int PAL_AW    = SELW + PXLW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic [LAYERS*PXLW-1:0] layer_pxl,
  input  logic [LAYERS-1:0]      gfx_en,
  input  logic [2:0]             prisel,
  input  logic [PRIO_AW-1:0]     prog_addr,
  input  logic [SELW-1:0]        prom_din,
  input  logic                   prom_we,
  jtframe_colmix_nl_if.slave     cpu,
  input  logic                   fade_start,
  input  logic                   fade_dir,
  input  logic [3:0]             fade_rate,
  output logic                   fade_busy,
  output logic [7:0]             red,
  output logic [7:0]             green,
  output logic [7:0]             blue,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly
);

  typedef enum logic {IDLE, RUN} fade_state_t;

  logic [15:0]            pal_mem  [0:2**PAL_AW-1];
  logic [SELW-1:0]        prom_mem [0:2**PRIO_AW-1];

  logic [LAYERS-1:0]      blank;
  logic [LAYERS*PXLW-1:0] s1_pxl;
  logic [LAYERS-1:0]      s1_blank;
  logic [2:0]             s1_prisel;
  logic [2:0]             hb_d, vb_d;
  logic [SELW-1:0]        prom_q, fix_sel, prom_sel, sel;
  logic [PXLW-1:0]        pxl_sel;
  logic [PAL_AW-1:0]      s2_addr;
  logic [11:0]            s3_word;
  logic [1:0]             pal_we;

  fade_state_t            state;
  logic [4:0]             level, target, next_level;
  logic [3:0]             frame_cnt;
  logic                   lvbl_last;
  logic                   lvbl_fall;

  // 8-bit channel from a 4-bit palette nibble scaled by the fade level (0..16)
  function automatic logic [7:0] scale(input logic [3:0] c4, input logic [4:0] lvl);
    logic [12:0] prod;
    prod = 13'({c4, c4}) * 13'(lvl);
    return 8'(prod >> 4);
  endfunction

  assign pal_we    = ~cpu.dsn & {2{cpu.pal_cs}};
  assign lvbl_fall = lvbl_last & ~LVBL;

  // Per-layer transparency flags from the live inputs
  always_comb begin
    blank = '0;
    for (int k = 0; k < LAYERS; k++)
      blank[k] = ~|layer_pxl[k*PXLW +: 4] | ~gfx_en[k];
  end

  // Layer choice: lowest non-blank index wins in fixed mode, PROM otherwise
  always_comb begin
    fix_sel = SELW'(LAYERS - 1);
    for (int k = LAYERS - 1; k >= 0; k--)
      fix_sel = s1_blank[k] ? fix_sel : SELW'(k);
    prom_sel = ({1'b0, prom_q} >= (SELW+1)'(LAYERS)) ? SELW'(LAYERS - 1) : prom_q;
    sel      = (PRIO_MODE != 0) ? prom_sel : fix_sel;
    pxl_sel  = s1_pxl[sel*PXLW +: PXLW];
  end

  // One step of the fade level toward its target
  always_comb begin
    next_level = level;
    if (level < target) next_level = level + 5'd1;
    else if (level > target) next_level = level - 5'd1;
    else next_level = level;
  end

  // Palette and PROM storage; no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (pal_we[0]) pal_mem[cpu.cpu_addr][7:0]  <= cpu.cpu_dout[7:0];
    if (pal_we[1]) pal_mem[cpu.cpu_addr][15:8] <= cpu.cpu_dout[15:8];
    if (prom_we)   prom_mem[prog_addr]         <= prom_din;
  end

  // Pixel pipeline S1..S3, PROM read every clk, CPU read-back port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_pxl      <= '0;
      s1_blank    <= '0;
      s1_prisel   <= 3'd0;
      hb_d        <= 3'd0;
      vb_d        <= 3'd0;
      prom_q      <= '0;
      s2_addr     <= '0;
      s3_word     <= 12'd0;
      cpu.cpu_din <= 16'd0;
    end else begin
      prom_q      <= prom_mem[PRIO_AW'({s1_prisel, s1_blank})];
      cpu.cpu_din <= pal_mem[cpu.cpu_addr];
      if (pxl_cen) begin
        s1_pxl    <= layer_pxl;
        s1_blank  <= blank;
        s1_prisel <= prisel;
        hb_d      <= {hb_d[1:0], LHBL};
        vb_d      <= {vb_d[1:0], LVBL};
        s2_addr   <= PAL_AW'({sel, pxl_sel});
        s3_word   <= pal_mem[s2_addr][11:0];
      end
    end
  end

  // S4: scaled colour and delayed blanking, black outside the active area
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red      <= 8'd0;
      green    <= 8'd0;
      blue     <= 8'd0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      LHBL_dly <= hb_d[2];
      LVBL_dly <= vb_d[2];
      if (hb_d[2] & vb_d[2]) begin
        red   <= scale(s3_word[3:0], level);
        green <= scale(s3_word[7:4], level);
        blue  <= scale(s3_word[11:8], level);
      end else begin
        red   <= 8'd0;
        green <= 8'd0;
        blue  <= 8'd0;
      end
    end
  end

  // Fade FSM: a start pulse overrides any frame event in the same clk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      level     <= 5'd16;
      target    <= 5'd16;
      frame_cnt <= 4'd0;
      fade_busy <= 1'b0;
      lvbl_last <= 1'b0;
    end else begin
      lvbl_last <= LVBL;
      if (fade_start) begin
        state     <= RUN;
        target    <= fade_dir ? 5'd16 : 5'd0;
        frame_cnt <= 4'd0;
        fade_busy <= 1'b1;
      end else if (state == RUN && lvbl_fall) begin
        if (frame_cnt == fade_rate) begin
          frame_cnt <= 4'd0;
          level     <= next_level;
          if (next_level == target) begin
            state     <= IDLE;
            fade_busy <= 1'b0;
          end
        end else begin
          frame_cnt <= frame_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: doc/jtframe_colmix_nl.md
Name: jtframe_colmix_nl

Overview:
- Parametrised N-layer colour mixer with built-in screen fade, replacing per-game fixed 4-layer mixers.
- Picks one of LAYERS tile/object layers per pixel, using either fixed order or a priority PROM indexed by blank flags and a game priority select.
- Looks up the selected pixel in a CPU-writable 12-bit BGR palette and expands it to 8-bit RGB.
- Applies a frame-stepped brightness fade and outputs RGB with delayed blanking to the video output stage.

Parameters:
- LAYERS, 4, number of input layers (2..8); SELW=$clog2(LAYERS).
- PXLW, 8, pixel width per layer; bits [3:0] zero = transparent.
- PRIO_MODE, 1, 0 = fixed order (layer 0 highest, last layer is the fallback); 1 = priority PROM.
- PRIO_AW, LAYERS+3, PROM address width, {prisel, blank[LAYERS-1:0]}.
- PAL_AW, SELW+PXLW, palette address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- pxl_cen  in  1  pixel enable; never asserted on two consecutive clk cycles.
- LHBL, LVBL  in  1 each  active-low blanking.
- layer_pxl  in  LAYERS*PXLW  layer k at [k*PXLW +: PXLW].
- gfx_en  in  LAYERS  debug layer enable; 0 forces that layer blank.
- prisel  in  3  game priority select.
- prog_addr  in  PRIO_AW  PROM load address.
- prom_din  in  SELW  PROM load data.
- prom_we  in  1  PROM write strobe.
- pal_cs  in  1  palette chip select.
- cpu_addr  in  PAL_AW  palette word address.
- cpu_dout  in  16  write data.
- dsn  in  2  active-low byte strobes.
- cpu_din  out  16  palette read data.
- fade_start  in  1  one-clk pulse starting a fade.
- fade_dir  in  1  1 = fade in (towards full), 0 = fade out (towards black).
- fade_rate  in  4  frames per brightness step, minus 1.
- fade_busy  out  1  fade in progress.
- red, green, blue  out  8 each  colour output.
- LHBL_dly, LVBL_dly  out  1 each  blanking aligned to RGB.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - RGB=0, LHBL_dly=LVBL_dly=0, cpu_din=0, fade_busy=0.
  - Fade state IDLE, level=16, frame counter=0.
  - All pipeline registers cleared. Palette and PROM contents are kept.
- Blank flag: blank[k] = ~|pxl_k[3:0] | ~gfx_en[k].
- Pipeline, every stage advancing on pxl_cen:
  - S1: latch layer_pxl, blank vector and prisel.
  - PROM: registered read every clk, addressed from S1 registers; the spacing rule on pxl_cen guarantees q is valid before the next pxl_cen.
  - S2: sel = PROM q (PRIO_MODE=1) or the lowest-index non-blank layer, else LAYERS-1 (PRIO_MODE=0); pal_addr = {sel, pxl_sel}.
  - S3: palette word latched.
  - S4: scaled RGB latched.
  - Latency is exactly 4 pxl_cen from input to RGB. LHBL/LVBL are delayed by the same 4 pxl_cen.
  - RGB is forced to 0 while LHBL_dly or LVBL_dly is low.
  - A PROM q value >= LAYERS selects layer LAYERS-1.
- Colour arithmetic:
  - Palette word is {x, b4, g4, r4}; c8 = {c4, c4}.
  - out = (c8 * level) >> 4, with a 13-bit product, truncated.
  - level=16 gives c8 unchanged; level=0 gives 0.
- Palette RAM (dual-port, 2^PAL_AW x 16):
  - Byte writes: we = ~dsn & {2{pal_cs}}.
  - cpu_din is registered with 1-clk read latency.
  - A same-clk CPU write and video read to one address returns the old data to the video side.
- PROM: written on prom_we at prog_addr, effective for the next read.
- Fade FSM:
  - IDLE -> RUN on fade_start: target = fade_dir ? 16 : 0, counter=0, fade_busy=1.
  - In RUN, each LVBL falling edge (detected at clk, not gated by pxl_cen) does the following:
    - if counter == fade_rate: counter=0 and level moves 1 toward target;
    - otherwise counter+1.
  - When level == target after a step: return to IDLE, fade_busy=0.
  - fade_start while in RUN restarts with the new direction from the current level; counter=0.
  - fade_start with level already at target: enter RUN, then exit on the first step event with no level change.
  - fade_start coinciding with an LVBL fall: the start wins and the fall is ignored.
  - Reset mid-fade: IDLE, level=16.

Test Plan:
- Reset, then palette[0x123]={4'h0,4'h3,4'h2,4'h1}, PRIO_MODE=0, layer1 pxl=0x23, layer0 pxl blank, level=16 -> after 4 pxl_cen, red=0x11, green=0x22, blue=0x33.
- PRIO_MODE=1, PROM[{3'd2,4'b0000}]=3, prisel=2, all layers non-blank -> pal_addr upper bits=3; layer3 colour output. gfx_en=4'b1110 -> address {3'd2,4'b0001} used.
- LHBL low for one pixel -> LHBL_dly low exactly 4 pxl_cen later, and RGB=0 for that pixel.
- fade_start with dir=0, rate=1 -> level steps 16 to 0 once every 2 frames; fade_busy drops after the 32nd LVBL fall. Mid-ramp at level 8, c8=0xFF -> 0x7F.
- At level 5, fade_start with dir=1 -> counter cleared, level rises to 16, fade_busy=1 throughout the ramp.
- CPU writes with dsn=2'b10 to 0x010 -> only the low byte changes. cpu_din is valid 1 clk after the address. A simultaneous video read of 0x010 returns the old word.
